// File: rtl/clkdiv_gen.sv
// ---------------------------------------------------------------------------
// clkdiv_gen
//
// Programmable, glitch-free clock divider. The divided clock and its edge
// strobes come straight from flops, so the downstream clock buffer only ever
// sees clean register transitions. Ratio changes and start/stop requests are
// applied only at period boundaries, so no runt high or low phase appears on
// clkout. Only the asynchronous reset can cut a phase short.
//
// Parameters
//   DW    width of the divide-ratio field and of the period counter
//   PROP  implementation property string for target-specific mapping;
//         it has no functional effect
//
// Ports
//   clk        in   source clock, all state changes on its rising edge
//   nreset     in   asynchronous active-low reset
//   en         in   run request, honoured at period boundaries
//   cfg_valid  in   a new divide ratio is offered
//   cfg_div    in   offered divide ratio N (0 and 1 are treated as 2)
//   cfg_ready  out  pending slot is empty, so an offer will be accepted
//   clkout     out  divided clock (flop output)
//   rise       out  high during the first high cycle of each period
//   fall       out  high during the first low cycle of each period
//   busy       out  divider is running
// ---------------------------------------------------------------------------
module clkdiv_gen #(
    parameter int DW   = 8,
    parameter     PROP = "DEFAULT"
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          en,
    input  logic          cfg_valid,
    input  logic [DW-1:0] cfg_div,
    output logic          cfg_ready,
    output logic          clkout,
    output logic          rise,
    output logic          fall,
    output logic          busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Ratios below 2 cannot form a high and a low phase.
    function automatic logic [DW-1:0] clamp_div(input logic [DW-1:0] d);
        return (d < DW'(2)) ? DW'(2) : d;
    endfunction

    // High-phase length ceil(N/2); odd ratios get the extra cycle high.
    function automatic logic [DW-1:0] high_len(input logic [DW-1:0] n);
        return (n >> 1) + {{(DW-1){1'b0}}, n[0]};
    endfunction

    // Hook for target-specific mapping keyed on PROP. The portable
    // implementation below is used for every value.
    if (PROP != "DEFAULT") begin : g_target_map
    end

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] ratio;
    logic [DW-1:0] ratio_nxt;
    logic [DW-1:0] cnt;
    logic [DW-1:0] cnt_nxt;
    logic [DW-1:0] high_nxt;
    logic [DW-1:0] pend_div;
    logic          pend_vld;
    logic          pend_vld_nxt;
    logic          take;
    logic          boundary;
    logic          clkout_nxt;
    logic          rise_nxt;
    logic          fall_nxt;

    assign cfg_ready = !pend_vld;
    assign take      = cfg_valid && !pend_vld;
    assign boundary  = (state == RUN) && (cnt == ratio - DW'(1));
    assign busy      = (state == RUN);

    always_comb begin
        state_nxt    = state;
        ratio_nxt    = ratio;
        cnt_nxt      = cnt;
        pend_vld_nxt = pend_vld;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (pend_vld) begin
                    ratio_nxt    = pend_div;
                    pend_vld_nxt = 1'b0;
                end
                if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (boundary) begin
                    cnt_nxt = '0;
                    if (pend_vld) begin
                        ratio_nxt    = pend_div;
                        pend_vld_nxt = 1'b0;
                    end
                    if (!en) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + DW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // An offer is only taken while the slot is empty, so it can never
        // collide with the slot being consumed in the same cycle.
        if (take) begin
            pend_vld_nxt = 1'b1;
        end

        // Outputs are derived from the next state so that they change on
        // the same edge as the counter and the ratio that governs them.
        high_nxt   = high_len(ratio_nxt);
        clkout_nxt = (state_nxt == RUN) && (cnt_nxt < high_nxt);
        rise_nxt   = (state_nxt == RUN) && (cnt_nxt == '0);
        fall_nxt   = (state_nxt == RUN) && (cnt_nxt == high_nxt);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state    <= IDLE;
            ratio    <= DW'(2);
            cnt      <= '0;
            pend_vld <= 1'b0;
            clkout   <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            state    <= state_nxt;
            ratio    <= ratio_nxt;
            cnt      <= cnt_nxt;
            pend_vld <= pend_vld_nxt;
            clkout   <= clkout_nxt;
            rise     <= rise_nxt;
            fall     <= fall_nxt;
        end
    end

    // Pending ratio payload; only meaningful while pend_vld is set.
    always_ff @(posedge clk) begin
        if (take) begin
            pend_div <= clamp_div(cfg_div);
        end
    end

endmodule

// File: tb/tb_clkdiv_gen.sv
module tb_clkdiv_gen;

    logic       clk;
    logic       nreset;
    logic       en;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       clkout;
    logic       rise;
    logic       fall;
    logic       busy;

    clkdiv_gen #(.DW(8), .PROP("DEFAULT")) dut (
        .clk       (clk),
        .nreset    (nreset),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .clkout    (clkout),
        .rise      (rise),
        .fall      (fall),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp = {clkout, rise, fall, busy, cfg_ready} after the edge that
    // samples the inputs en / cv / div.
    typedef struct {
        string      grp;
        logic       en;
        logic       cv;
        logic [7:0] div;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void add(string g, logic e, logic c, logic [7:0] d, logic [4:0] x);
        vec_t v;
        v.grp = g;
        v.en  = e;
        v.cv  = c;
        v.div = d;
        v.exp = x;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [4:0] act, logic [4:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b required %b ({clkout,rise,fall,busy,cfg_ready}) t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Drives each queued vector, pushes its expectation to the scoreboard,
    // then pops and compares one cycle later.
    task automatic run_vecs();
        vec_t v;
        for (int i = 0; i < vecs.size(); i++) begin
            en        = vecs[i].en;
            cfg_valid = vecs[i].cv;
            cfg_div   = vecs[i].div;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_empty at vector %0d", i);
            end else begin
                v = sb.pop_front();
                check($sformatf("%s[%0d]", v.grp, i), {clkout, rise, fall, busy, cfg_ready}, v.exp);
            end
        end
        vecs.delete();
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
    endtask

    initial begin
        nreset    = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        #3;
        check("reset_values", {clkout, rise, fall, busy, cfg_ready}, 5'b00001);
        repeat (2) @(posedge clk);
        @(negedge clk);
        nreset = 1'b1;

        // Default N=2 after reset
        add("n2_run", 1, 0, 0, 5'b11011);
        add("n2_run", 1, 0, 0, 5'b00111);
        add("n2_run", 1, 0, 0, 5'b11011);
        add("n2_run", 0, 0, 0, 5'b00111);
        add("n2_run", 0, 0, 0, 5'b00001);
        add("n2_run", 0, 0, 0, 5'b00001);

        // N=5 loaded in IDLE, two full periods, then stop
        add("n5_cfg", 0, 1, 5, 5'b00000);
        add("n5_cfg", 0, 0, 0, 5'b00001);
        for (int p = 0; p < 2; p++) begin
            add("n5_run", 1, 0, 0, 5'b11011);
            add("n5_run", 1, 0, 0, 5'b10011);
            add("n5_run", 1, 0, 0, 5'b10011);
            add("n5_run", 1, 0, 0, 5'b00111);
            add("n5_run", 1, 0, 0, 5'b00011);
        end
        add("n5_stop", 0, 0, 0, 5'b00001);

        // N=4 running, offer 6 at c=1: this period stays 4, next is 6
        add("n4_cfg", 0, 1, 4, 5'b00000);
        add("n4_run", 1, 0, 0, 5'b11011);
        add("n4_run", 1, 0, 0, 5'b10011);
        add("n4_offer6", 1, 1, 6, 5'b00110);
        add("n4_run", 1, 0, 0, 5'b00010);
        add("n6_run", 1, 0, 0, 5'b11011);
        add("n6_run", 1, 0, 0, 5'b10011);
        add("n6_run", 1, 0, 0, 5'b10011);
        add("n6_run", 1, 0, 0, 5'b00111);
        add("n6_run", 1, 0, 0, 5'b00011);
        add("n6_run", 1, 0, 0, 5'b00011);
        add("n6_stop", 0, 0, 0, 5'b00001);

        // cfg_div=0 clamps to 2; offer on a boundary applies one period later
        add("clamp0", 0, 1, 0, 5'b00000);
        add("clamp0", 0, 0, 0, 5'b00001);
        add("clamp0_run", 1, 0, 0, 5'b11011);
        add("clamp0_run", 1, 0, 0, 5'b00111);
        add("bnd_offer8", 1, 1, 8, 5'b11010);
        add("bnd_offer8", 1, 0, 0, 5'b00110);
        // N=8, en dropped at c=2 with a mid-period blip: period completes
        add("n8_run", 1, 0, 0, 5'b11011);
        add("n8_run", 1, 0, 0, 5'b10011);
        add("n8_run", 1, 0, 0, 5'b10011);
        add("n8_drop", 0, 0, 0, 5'b10011);
        add("n8_drop", 0, 0, 0, 5'b00111);
        add("n8_drop", 1, 0, 0, 5'b00011);
        add("n8_drop", 0, 0, 0, 5'b00011);
        add("n8_drop", 0, 0, 0, 5'b00011);
        add("n8_stop", 0, 0, 0, 5'b00001);
        add("n8_stop", 0, 0, 0, 5'b00001);
        add("n8_restart", 1, 0, 0, 5'b11011);
        // cfg_div=1 clamps to 2; offer of 9 while pending full is held off
        add("clamp1", 1, 1, 1, 5'b10010);
        add("held_off9", 1, 1, 9, 5'b10010);
        add("held_off9", 1, 1, 9, 5'b10010);
        add("n8_tail", 1, 0, 0, 5'b00110);
        add("n8_tail", 1, 0, 0, 5'b00010);
        add("n8_tail", 1, 0, 0, 5'b00010);
        add("n8_tail", 1, 0, 0, 5'b00010);
        add("clamp1_run", 1, 0, 0, 5'b11011);
        add("clamp1_run", 1, 0, 0, 5'b00111);
        add("clamp1_run", 1, 0, 0, 5'b11011);
        add("clamp1_run", 0, 0, 0, 5'b00111);
        add("clamp1_stop", 0, 0, 0, 5'b00001);

        // N=6 running up to c=1, then asynchronous reset
        add("n6_pre_rst", 0, 1, 6, 5'b00000);
        add("n6_pre_rst", 1, 0, 0, 5'b11011);
        add("n6_pre_rst", 1, 0, 0, 5'b10011);
        run_vecs();

        // Reset mid-period: outputs clear without a clock edge
        en = 1'b1;
        #2;
        nreset = 1'b0;
        #1;
        check("async_reset", {clkout, rise, fall, busy, cfg_ready}, 5'b00001);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", {clkout, rise, fall, busy, cfg_ready}, 5'b00001);
        @(negedge clk);
        en     = 1'b0;
        nreset = 1'b1;

        // First edge after release is IDLE; ratio is back to 2
        add("post_rst", 0, 0, 0, 5'b00001);
        add("post_rst", 1, 0, 0, 5'b11011);
        add("post_rst", 0, 0, 0, 5'b00111);
        add("post_rst", 0, 0, 0, 5'b00001);
        run_vecs();

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_leftover: %0d entries, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
